sp_issue_queue: RTL and testbench
=================================

Name: sp_issue_queue

Overview:
- Parametrised instruction-issue front end between an instruction loader (test pattern or boot loader) and the simple-processor core (`SP` / `SP_pipeline`).
- Buffers {inst_addr, inst} pairs in a FIFO and drives `in_valid`/`inst`/`inst_addr` one instruction per cycle.
- Tracks in-flight instructions against the core's `out_valid` retirements.
- Supports single-cycle (issue-then-wait) and pipelined (bounded in-flight) modes, with timeout and spurious-retire error detection.

Parameters:
- DATA_W, 32, width of inst and inst_addr.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- MODE, 1, 0 = single-cycle core (limit 1 in flight), 1 = pipelined core (limit MAX_INFLIGHT).
- MAX_INFLIGHT, 5, in-flight limit when MODE = 1; range 1..255.
- TIMEOUT, 1000, cycles without retirement, while in flight > 0, before timeout_err is set.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- ld_valid  in  1  loader presents an entry.
- ld_ready  out  1  queue accepts the entry (FIFO not full).
- ld_inst  in  DATA_W  instruction word.
- ld_addr  in  DATA_W  instruction address.
- in_valid  out  1  issue strobe to the core, registered.
- inst  out  DATA_W  issued instruction, registered.
- inst_addr  out  DATA_W  issued address, registered.
- out_valid  in  1  core retirement strobe.
- inflight  out  8  count of issued but not retired instructions.
- retired_cnt  out  32  total retirements since reset; wraps.
- idle  out  1  FIFO empty and inflight == 0.
- timeout_err  out  1  sticky.
- spurious_err  out  1  sticky; set by out_valid while inflight == 0.

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk):
  - FIFO empty; in_valid = 0; inst = 0; inst_addr = 0.
  - inflight = 0; retired_cnt = 0; timeout counter = 0.
  - Both error flags = 0.
  - idle = 1; ld_ready = 1.
  - Reset mid-operation discards all queued and in-flight state. out_valid in the reset cycle is ignored.
- Load:
  - Entry written when ld_valid && ld_ready.
  - ld_ready = !full, combinational from registered state only.
- Issue condition, evaluated each cycle: FIFO non-empty && inflight < LIMIT && !timeout_err.
  - LIMIT = 1 when MODE = 0, MAX_INFLIGHT when MODE = 1.
  - When true, the next edge pops the head, in_valid = 1, and inst/inst_addr = head.
  - Otherwise in_valid = 0 and inst/inst_addr hold their previous values.
  - At most one issue per cycle.
- Latency: an entry loaded into an empty FIFO at edge t appears with in_valid = 1 after edge t+1. No bypass.
- FIFO:
  - Circular read/write pointers with an extra wrap bit.
  - Full and empty are decided from the pointers; wrap-around is seamless.
  - Simultaneous push and pop when full: push is refused (ld_ready = 0), pop proceeds.
  - Simultaneous push and pop when non-empty, non-full: both occur; occupancy is unchanged.
- inflight update: +1 on issue, -1 on out_valid; both in the same cycle leaves it unchanged.
  - A retirement freeing a slot is visible to the issue condition the following cycle (inflight is registered).
- Spurious retire: out_valid while inflight == 0 and no issue this cycle.
  - Sets spurious_err.
  - inflight stays 0 (no underflow) and retired_cnt is not incremented.
- retired_cnt: +1 per valid retirement; 32-bit wrap to 0.
- Timeout:
  - Counter increments each cycle while inflight > 0 and out_valid = 0.
  - Clears on any out_valid or when inflight == 0.
  - When the counter reaches TIMEOUT-1 and increments, timeout_err is set.
  - While timeout_err is set, issue stops; loads are still accepted until full.
  - Error flags clear only on rst.
- idle is combinational from registered state.

Test Plan:
- MODE = 1, MAX_INFLIGHT = 5; load 8 entries back-to-back (addr 0,4,…,28), out_valid held 0 -> 5 issues on consecutive cycles, then in_valid = 0, inflight = 5, ld_ready re-asserts after the pops.
- MODE = 0; load 3 entries; core returns out_valid 4 cycles after each issue -> every in_valid is separated by retirement, inflight never exceeds 1, retired_cnt = 3, idle = 1 at end.
- Fill DEPTH = 8 with ld_valid held high and issue blocked -> ld_ready = 0 after 8 accepts; 9th entry accepted only in the cycle after the first pop; 20 entries with pointer wrap issue in the exact load order.
- Issue 1 instruction, never retire, TIMEOUT = 16 -> timeout_err = 1 after 16 cycles; further queued entries are not issued; rst clears flag, inflight and FIFO.
- out_valid pulsed with idle = 1 -> spurious_err = 1, inflight = 0, retired_cnt unchanged; issue and retire in the same cycle with inflight = 2 -> inflight stays 2.
- Assert rst while inflight = 3 and FIFO holds 4 -> next cycle in_valid = 0, inflight = 0, idle = 1, ld_ready = 1; subsequent load issues normally.

Source files
------------

// File: rtl/sp_issue_queue_if.sv
// Loader-to-queue and queue-to-core handshake signals for sp_issue_queue.
// master is the queue's view; slave is the loader/core side.
interface sp_issue_queue_if #(
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_inst;
  logic [DATA_W-1:0] ld_addr;
  logic              in_valid;
  logic [DATA_W-1:0] inst;
  logic [DATA_W-1:0] inst_addr;
  logic              out_valid;

  modport master (
    input  ld_valid, ld_inst, ld_addr, out_valid,
    output ld_ready, in_valid, inst, inst_addr
  );

  modport slave (
    output ld_valid, ld_inst, ld_addr, out_valid,
    input  ld_ready, in_valid, inst, inst_addr
  );
endinterface

// File: rtl/sp_issue_queue.sv
// Instruction issue front end: FIFO of {addr, inst} pairs feeding the SP core,
// with in-flight tracking, retirement counting and timeout/spurious-retire detection.
module sp_issue_queue #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int MODE         = 1,
  parameter int MAX_INFLIGHT = 5,
  parameter int TIMEOUT      = 1000
) (
  input  logic                clk,
  input  logic                rst,
  sp_issue_queue_if.master    bus,
  output logic [7:0]          inflight,
  output logic [31:0]         retired_cnt,
  output logic                idle,
  output logic                timeout_err,
  output logic                spurious_err
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [7:0]  LIMIT   = (MODE == 0) ? 8'd1 : 8'(MAX_INFLIGHT);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] TO_SAT  = 32'(TIMEOUT);

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [31:0]         to_cnt;
  logic                empty;
  logic                full;
  logic                push;
  logic                issue;
  logic                retire;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push   = bus.ld_valid && !full;
    issue  = !empty && (inflight < LIMIT) && !timeout_err;
    retire = bus.out_valid && ((inflight != 8'd0) || issue);
  end

  assign bus.ld_ready = !full;
  assign idle         = empty && (inflight == 8'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {bus.ld_addr, bus.ld_inst};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.in_valid  <= 1'b0;
      bus.inst      <= '0;
      bus.inst_addr <= '0;
    end else begin
      bus.in_valid <= issue;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr                    <= rd_ptr + 1'b1;
        {bus.inst_addr, bus.inst} <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // A retire with nothing in flight and no same-cycle issue is flagged, never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= 8'd0;
      retired_cnt  <= 32'd0;
      spurious_err <= 1'b0;
    end else begin
      case ({issue, retire})
        2'b10:   inflight <= inflight + 8'd1;
        2'b01:   inflight <= inflight - 8'd1;
        default: inflight <= inflight;
      endcase
      if (retire) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (bus.out_valid && !retire) begin
        spurious_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= 32'd0;
      timeout_err <= 1'b0;
    end else if (bus.out_valid || (inflight == 8'd0)) begin
      to_cnt <= 32'd0;
    end else if (to_cnt != TO_SAT) begin
      to_cnt <= to_cnt + 32'd1;
      if (to_cnt == TO_LAST) begin
        timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sp_issue_queue.sv
// Directed bench for sp_issue_queue: a pipelined instance (limit 5, timeout 16)
// and a single-cycle instance, checked with immediate assertions.
module tb_sp_issue_queue;
  logic clk;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  sp_issue_queue_if #(.DATA_W(32)) pbus ();
  sp_issue_queue_if #(.DATA_W(32)) sbus ();

  logic [7:0]  p_inflight;
  logic [31:0] p_retired;
  logic        p_idle;
  logic        p_to;
  logic        p_sp;
  logic [7:0]  s_inflight;
  logic [31:0] s_retired;
  logic        s_idle;
  logic        s_to;
  logic        s_sp;

  sp_issue_queue #(
    .DATA_W(32), .DEPTH(8), .MODE(1), .MAX_INFLIGHT(5), .TIMEOUT(16)
  ) u_pipe (
    .clk(clk), .rst(rst), .bus(pbus.master),
    .inflight(p_inflight), .retired_cnt(p_retired), .idle(p_idle),
    .timeout_err(p_to), .spurious_err(p_sp)
  );

  sp_issue_queue #(
    .DATA_W(32), .DEPTH(8), .MODE(0), .MAX_INFLIGHT(5), .TIMEOUT(16)
  ) u_single (
    .clk(clk), .rst(rst), .bus(sbus.master),
    .inflight(s_inflight), .retired_cnt(s_retired), .idle(s_idle),
    .timeout_err(s_to), .spurious_err(s_sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction word is derived from the address so the bench can predict it.
  task automatic apply_stimulus(input logic v, input logic [31:0] addr, input logic ov);
    pbus.ld_valid  = v;
    pbus.ld_addr   = addr;
    pbus.ld_inst   = addr ^ 32'hA5A5_0000;
    pbus.out_valid = ov;
  endtask

  initial begin
    int   next_ld;
    int   next_iss;
    int   k;
    int   ov_edge;
    int   n_ret;
    bit   pending;
    logic accept;

    rst = 1'b1;
    apply_stimulus(1'b0, 32'd0, 1'b0);
    sbus.ld_valid  = 1'b0;
    sbus.ld_addr   = '0;
    sbus.ld_inst   = '0;
    sbus.out_valid = 1'b0;
    tick();
    tick();

    check_output("rst_in_valid", 32'(pbus.in_valid), 0);
    check_output("rst_inst", pbus.inst, 0);
    check_output("rst_inst_addr", pbus.inst_addr, 0);
    check_output("rst_inflight", 32'(p_inflight), 0);
    check_output("rst_retired", p_retired, 0);
    check_output("rst_idle", 32'(p_idle), 1);
    check_output("rst_ld_ready", 32'(pbus.ld_ready), 1);
    check_output("rst_timeout", 32'(p_to), 0);
    check_output("rst_spurious", 32'(p_sp), 0);
    check_output("rst_single_idle", 32'(s_idle), 1);
    rst = 1'b0;

    // Eight back-to-back loads, no retirements: five issues then the limit holds.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 32'(4 * i), 1'b0);
      tick();
      check_output("burst_in_valid", 32'(pbus.in_valid), 32'((i >= 1) && (i <= 5)));
      if ((i >= 1) && (i <= 5)) begin
        check_output("burst_addr", pbus.inst_addr, 32'(4 * (i - 1)));
        check_output("burst_inst", pbus.inst, 32'(4 * (i - 1)) ^ 32'hA5A5_0000);
      end
      check_output("burst_inflight", 32'(p_inflight), 32'((i > 5) ? 5 : i));
      check_output("burst_ld_ready", 32'(pbus.ld_ready), 1);
    end
    apply_stimulus(1'b0, 32'd0, 1'b0);

    // First issue landed on edge 2, so the flag must rise on edge 18, not 17.
    for (int i = 0; i < 9; i++) tick();
    check_output("timeout_early", 32'(p_to), 0);
    tick();
    check_output("timeout_set", 32'(p_to), 1);
    check_output("timeout_inflight", 32'(p_inflight), 5);
    apply_stimulus(1'b0, 32'd0, 1'b1);
    tick();
    check_output("to_retire_inflight", 32'(p_inflight), 4);
    check_output("to_retire_cnt", p_retired, 1);
    apply_stimulus(1'b0, 32'd0, 1'b0);
    tick();
    check_output("to_blocks_issue", 32'(pbus.in_valid), 0);
    check_output("to_blocks_inflight", 32'(p_inflight), 4);
    check_output("to_sticky", 32'(p_to), 1);

    rst = 1'b1;
    apply_stimulus(1'b1, 32'h40, 1'b1);
    tick();
    check_output("to_rst_flag", 32'(p_to), 0);
    check_output("to_rst_inflight", 32'(p_inflight), 0);
    check_output("to_rst_idle", 32'(p_idle), 1);
    check_output("to_rst_retired", p_retired, 0);
    rst = 1'b0;
    apply_stimulus(1'b0, 32'd0, 1'b0);
    tick();
    check_output("to_rst_fifo_clear", 32'(pbus.in_valid), 0);
    check_output("to_rst_idle2", 32'(p_idle), 1);

    // 20 entries through an 8-deep FIFO: fill, refuse, refill after a pop, wrap.
    next_ld  = 0;
    next_iss = 0;
    k        = 0;
    while ((next_iss < 20) && (k < 100)) begin
      k++;
      apply_stimulus(next_ld < 20, 32'(32'h100 + 4 * next_ld), (k == 14) || (k >= 16));
      accept = pbus.ld_valid && pbus.ld_ready;
      tick();
      if (accept) next_ld++;
      if (pbus.in_valid) begin
        check_output("wrap_order_addr", pbus.inst_addr, 32'(32'h100 + 4 * next_iss));
        check_output("wrap_order_inst", pbus.inst, 32'(32'h100 + 4 * next_iss) ^ 32'hA5A5_0000);
        next_iss++;
      end
      if (k == 12) check_output("fill_ready_7", 32'(pbus.ld_ready), 1);
      if (k == 13) check_output("fill_ready_full", 32'(pbus.ld_ready), 0);
      if (k == 14) check_output("fill_retire_inflight", 32'(p_inflight), 4);
      if (k == 15) begin
        check_output("fill_ready_after_pop", 32'(pbus.ld_ready), 1);
        check_output("fill_inflight_15", 32'(p_inflight), 5);
        check_output("fill_not_yet_accepted", 32'(next_ld), 13);
      end
      if (k == 16) begin
        check_output("fill_accepted_after_pop", 32'(next_ld), 14);
        check_output("fill_ready_full2", 32'(pbus.ld_ready), 0);
        check_output("fill_inflight_16", 32'(p_inflight), 4);
      end
    end
    check_output("wrap_done_edge", 32'(k), 30);
    check_output("wrap_issued", 32'(next_iss), 20);
    check_output("wrap_inflight", 32'(p_inflight), 4);
    check_output("wrap_retired", p_retired, 16);

    apply_stimulus(1'b0, 32'd0, 1'b1);
    repeat (4) tick();
    apply_stimulus(1'b0, 32'd0, 1'b0);
    check_output("drain_inflight", 32'(p_inflight), 0);
    check_output("drain_retired", p_retired, 20);
    check_output("drain_idle", 32'(p_idle), 1);
    check_output("drain_spurious", 32'(p_sp), 0);
    check_output("drain_timeout", 32'(p_to), 0);

    // Retirement strobe with nothing in flight.
    apply_stimulus(1'b0, 32'd0, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0);
    check_output("spur_flag", 32'(p_sp), 1);
    check_output("spur_inflight", 32'(p_inflight), 0);
    check_output("spur_retired", p_retired, 20);

    // Issue and retire in the same cycle with two in flight.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'(32'h300 + 4 * i), 1'b0);
      tick();
    end
    check_output("same_pre_inflight", 32'(p_inflight), 2);
    apply_stimulus(1'b0, 32'd0, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0);
    check_output("same_in_valid", 32'(pbus.in_valid), 1);
    check_output("same_addr", pbus.inst_addr, 32'h308);
    check_output("same_inflight", 32'(p_inflight), 2);
    check_output("same_retired", p_retired, 21);

    // Reset in the middle of traffic; out_valid during reset must be ignored.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'(32'h400 + 4 * i), 1'b0);
      tick();
    end
    check_output("mid_pre_inflight", 32'(p_inflight), 4);
    check_output("mid_pre_in_valid", 32'(pbus.in_valid), 1);
    check_output("mid_pre_idle", 32'(p_idle), 0);
    rst = 1'b1;
    apply_stimulus(1'b1, 32'h4F0, 1'b1);
    tick();
    check_output("mid_rst_in_valid", 32'(pbus.in_valid), 0);
    check_output("mid_rst_inflight", 32'(p_inflight), 0);
    check_output("mid_rst_idle", 32'(p_idle), 1);
    check_output("mid_rst_ld_ready", 32'(pbus.ld_ready), 1);
    check_output("mid_rst_retired", p_retired, 0);
    check_output("mid_rst_spurious", 32'(p_sp), 0);
    rst = 1'b0;
    apply_stimulus(1'b1, 32'h500, 1'b0);
    tick();
    check_output("post_rst_latency", 32'(pbus.in_valid), 0);
    check_output("post_rst_busy", 32'(p_idle), 0);
    apply_stimulus(1'b0, 32'd0, 1'b0);
    tick();
    check_output("post_rst_issue", 32'(pbus.in_valid), 1);
    check_output("post_rst_addr", pbus.inst_addr, 32'h500);
    check_output("post_rst_inflight", 32'(p_inflight), 1);
    apply_stimulus(1'b0, 32'd0, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0);
    check_output("post_rst_idle", 32'(p_idle), 1);
    check_output("post_rst_retired", p_retired, 1);

    // Single-cycle core answering four cycles after each issue.
    ov_edge = -1;
    n_ret   = 0;
    next_iss = 0;
    pending = 1'b0;
    k       = 0;
    while ((n_ret < 3) && (k < 60)) begin
      k++;
      sbus.ld_valid  = (k <= 3);
      sbus.ld_addr   = 32'(32'h200 + 4 * (k - 1));
      sbus.ld_inst   = sbus.ld_addr ^ 32'hA5A5_0000;
      sbus.out_valid = (ov_edge == k);
      tick();
      if (ov_edge == k) begin
        pending = 1'b0;
        n_ret++;
      end
      if (sbus.in_valid) begin
        check_output("sc_issue_gap", 32'(pending), 0);
        check_output("sc_addr", sbus.inst_addr, 32'(32'h200 + 4 * next_iss));
        next_iss++;
        pending = 1'b1;
        ov_edge = k + 4;
      end
      check_output("sc_inflight", 32'(s_inflight), 32'(pending));
    end
    sbus.ld_valid  = 1'b0;
    sbus.out_valid = 1'b0;
    check_output("sc_done_edge", 32'(k), 16);
    check_output("sc_issued", 32'(next_iss), 3);
    check_output("sc_retired", s_retired, 3);
    check_output("sc_idle", 32'(s_idle), 1);
    check_output("sc_spurious", 32'(s_sp), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
